hazard_ctrl_mc: RTL and testbench

//  Generalised hazard/forwarding controller for the 5-stage pipelined MIPS core.

---
 rtl/hazard_ctrl_mc.sv | 123 ++++++++++++
 tb/tb_hazard_ctrl_mc.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_mc.sv
// Hazard/forwarding controller for the 5-stage MIPS pipeline: forwarding, stalls, flushes, MUL/DIV busy, dmem wait.
// Forward/stall/flush outputs are combinational on the current stage state; the dmem wait freezes F..M until DmemReady.
module hazard_ctrl_mc #(
    parameter int AW     = 5,
    parameter int MD_LAT = 4,
    parameter int CW     = 16
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic [AW-1:0] rsD,
    input  logic [AW-1:0] rtD,
    input  logic [AW-1:0] rsE,
    input  logic [AW-1:0] rtE,
    input  logic [AW-1:0] rtdE,
    input  logic [AW-1:0] rtdM,
    input  logic [AW-1:0] rtdW,
    input  logic          RFWEE,
    input  logic          RFWEM,
    input  logic          RFWEW,
    input  logic          MtoRFSelE,
    input  logic          MtoRFSelM,
    input  logic          BranchD,
    input  logic          JumpD,
    input  logic          MdStartE,
    input  logic          MdUseD,
    input  logic          MemReqM,
    input  logic          DmemReady,
    output logic [1:0]    ForwardAE,
    output logic [1:0]    ForwardBE,
    output logic          ForwardAD,
    output logic          ForwardBD,
    output logic          StallF,
    output logic          StallD,
    output logic          StallE,
    output logic          StallM,
    output logic          FlushD,
    output logic          FlushE,
    output logic          MdBusy,
    output logic [CW-1:0] StallCycles
);
    localparam int MDW = $clog2(MD_LAT + 1);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t         state_q, state_d;
    logic [MDW-1:0] md_cnt_q, md_cnt_d;
    logic [CW-1:0]  stall_cnt_q, stall_cnt_d;

    logic lw_stall, br_stall, md_stall, mem_hold, busy;

    always_comb begin
        busy     = (md_cnt_q != '0);
        lw_stall = MtoRFSelE && (rtdE != '0) && ((rtdE == rsD) || (rtdE == rtD));
        br_stall = BranchD &&
                   ((RFWEE && (rtdE != '0) && ((rtdE == rsD) || (rtdE == rtD))) ||
                    (MtoRFSelM && (rtdM != '0) && ((rtdM == rsD) || (rtdM == rtD))));
        md_stall = MdUseD && busy;
        mem_hold = (state_q == RUN) ? (MemReqM && !DmemReady) : !DmemReady;

        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        ForwardAD = 1'b0;
        ForwardBD = 1'b0;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        MdBusy    = 1'b0;

        // Every output is held at zero while reset is asserted, combinational ones too.
        if (RST_N) begin
            if ((rsE != '0) && RFWEM && (rsE == rtdM))      ForwardAE = 2'b10;
            else if ((rsE != '0) && RFWEW && (rsE == rtdW)) ForwardAE = 2'b01;
            if ((rtE != '0) && RFWEM && (rtE == rtdM))      ForwardBE = 2'b10;
            else if ((rtE != '0) && RFWEW && (rtE == rtdW)) ForwardBE = 2'b01;
            ForwardAD = (rsD != '0) && RFWEM && (rsD == rtdM);
            ForwardBD = (rtD != '0) && RFWEM && (rtD == rtdM);
            MdBusy    = busy;

            if (mem_hold) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
            end else if (lw_stall || br_stall || md_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end else begin
                FlushD = JumpD;
            end
        end
        StallCycles = stall_cnt_q;

        state_d = state_q;
        case (state_q)
            RUN:      if (MemReqM && !DmemReady) state_d = MEM_WAIT;
            MEM_WAIT: if (DmemReady)             state_d = RUN;
            default:                             state_d = RUN;
        endcase

        // md_stall keeps a second MdStartE out of E while busy, so it is ignored here.
        if (MdStartE && !busy) md_cnt_d = MDW'(MD_LAT);
        else if (busy)         md_cnt_d = md_cnt_q - 1'b1;
        else                   md_cnt_d = md_cnt_q;

        stall_cnt_d = (StallF && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= RUN;
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Directed bench for hazard_ctrl_mc (AW=5, MD_LAT=4, CW=4) with a running model of the stall-cycle counter.
module tb_hazard_ctrl_mc;
    logic       CLK = 1'b0;
    logic       RST_N;
    logic [4:0] rsD, rtD, rsE, rtE, rtdE, rtdM, rtdW;
    logic       RFWEE, RFWEM, RFWEW, MtoRFSelE, MtoRFSelM, BranchD, JumpD;
    logic       MdStartE, MdUseD, MemReqM, DmemReady;
    logic [1:0] ForwardAE, ForwardBE;
    logic       ForwardAD, ForwardBD, StallF, StallD, StallE, StallM, FlushD, FlushE, MdBusy;
    logic [3:0] StallCycles;

    int n_cmp = 0;
    int n_err = 0;
    int exp_sc = 0;

    hazard_ctrl_mc #(.AW(5), .MD_LAT(4), .CW(4)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .rtdE(rtdE), .rtdM(rtdM), .rtdW(rtdW),
        .RFWEE(RFWEE), .RFWEM(RFWEM), .RFWEW(RFWEW),
        .MtoRFSelE(MtoRFSelE), .MtoRFSelM(MtoRFSelM),
        .BranchD(BranchD), .JumpD(JumpD),
        .MdStartE(MdStartE), .MdUseD(MdUseD),
        .MemReqM(MemReqM), .DmemReady(DmemReady),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .MdBusy(MdBusy),
        .StallCycles(StallCycles)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        rsD = 0; rtD = 0; rsE = 0; rtE = 0; rtdE = 0; rtdM = 0; rtdW = 0;
        RFWEE = 0; RFWEM = 0; RFWEW = 0; MtoRFSelE = 0; MtoRFSelM = 0;
        BranchD = 0; JumpD = 0; MdStartE = 0; MdUseD = 0; MemReqM = 0; DmemReady = 0;
    endtask

    task automatic settle();
        #1;
    endtask

    // st: StallF expected at the coming edge, so the counter model advances with it.
    task automatic tick(input bit st);
        if (st && exp_sc != 15) exp_sc++;
        @(posedge CLK);
        #2;
    endtask

    task automatic chk_stalls(input string tag, input logic [5:0] exp);
        chk(tag, {26'd0, StallF, StallD, StallE, StallM, FlushD, FlushE}, {26'd0, exp});
    endtask

    initial begin
        clear_inputs();
        RST_N = 1'b0;
        rsE = 5; rtdM = 5; RFWEM = 1; MemReqM = 1;
        #3;
        chk("rst_fwdAE", ForwardAE, 0);
        chk_stalls("rst_stalls", 6'b000000);
        chk("rst_cnt", StallCycles, 0);
        @(posedge CLK); #2;
        RST_N = 1'b1;
        clear_inputs();
        settle();
        chk_stalls("idle_stalls", 6'b000000);
        chk("idle_busy", MdBusy, 0);

        // Forwarding priority and register-0 exclusion
        rsE = 5; rtdM = 5; RFWEM = 1; rtdW = 5; RFWEW = 1; settle();
        chk("fwdAE_M_over_W", ForwardAE, 2'b10);
        RFWEM = 0; settle();
        chk("fwdAE_W", ForwardAE, 2'b01);
        rsE = 0; RFWEM = 1; rtdM = 0; rtdW = 0; settle();
        chk("fwdAE_r0", ForwardAE, 2'b00);
        clear_inputs();
        rtE = 7; rtdW = 7; RFWEW = 1; settle();
        chk("fwdBE_W", ForwardBE, 2'b01);
        rsD = 3; rtD = 4; rtdM = 3; RFWEM = 1; settle();
        chk("fwdAD", ForwardAD, 1);
        chk("fwdBD", ForwardBD, 0);
        clear_inputs();

        // Load-use stall for exactly one cycle
        MtoRFSelE = 1; rtdE = 8; rtD = 8; settle();
        chk_stalls("lw_stall", 6'b110001);
        tick(1);
        clear_inputs(); settle();
        chk_stalls("lw_clear", 6'b000000);
        chk("cnt_after_lw", StallCycles, exp_sc);

        // Jump flush, and a load-use stall overriding it
        JumpD = 1; settle();
        chk_stalls("jump", 6'b000010);
        MtoRFSelE = 1; rtdE = 8; rtD = 8; settle();
        chk_stalls("jump_lw", 6'b110001);
        clear_inputs();
        BranchD = 1; RFWEE = 1; rtdE = 9; rsD = 9; settle();
        chk_stalls("br_stall_E", 6'b110001);
        RFWEE = 0; rtdE = 0; MtoRFSelM = 1; rtdM = 9; settle();
        chk_stalls("br_stall_M", 6'b110001);
        clear_inputs(); settle();

        // MUL/DIV busy window
        MdStartE = 1; settle();
        chk("md_t0_busy", MdBusy, 0);
        tick(0);
        MdStartE = 0; MdUseD = 1;
        for (int i = 1; i <= 4; i++) begin
            settle();
            chk($sformatf("md_t%0d_busy", i), MdBusy, 1);
            chk_stalls($sformatf("md_t%0d_stall", i), 6'b110001);
            tick(1);
        end
        settle();
        chk("md_t5_busy", MdBusy, 0);
        chk_stalls("md_t5_stall", 6'b000000);
        MdUseD = 0;
        chk("cnt_after_md", StallCycles, exp_sc);

        // Data-memory wait masks a concurrent load-use stall
        MemReqM = 1; DmemReady = 0; MtoRFSelE = 1; rtdE = 8; rtD = 8;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk_stalls($sformatf("mem_hold%0d", i), 6'b111100);
            tick(1);
        end
        DmemReady = 1; settle();
        chk_stalls("mem_done_lw", 6'b110001);
        tick(1);
        clear_inputs(); settle();
        chk_stalls("mem_back_run", 6'b000000);
        chk("cnt_after_mem", StallCycles, exp_sc);

        // Counter saturation, then reset in the middle of a memory wait
        MemReqM = 1; DmemReady = 0;
        for (int i = 0; i < 10; i++) tick(1);
        settle();
        chk("cnt_sat", StallCycles, 15);
        chk("sat_stallM", StallM, 1);
        rsE = 5; rtdM = 5; RFWEM = 1;
        RST_N = 1'b0; settle();
        chk_stalls("rst_mid_wait", 6'b000000);
        chk("rst_mid_cnt", StallCycles, 0);
        chk("rst_mid_fwd", ForwardAE, 0);
        exp_sc = 0;
        clear_inputs();
        @(posedge CLK); #2;
        RST_N = 1'b1; settle();
        chk_stalls("post_rst_run", 6'b000000);
        tick(0);
        settle();
        chk("post_rst_cnt", StallCycles, exp_sc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
